// File: rtl/serial_pkg.sv
// Shared definitions for the serial receiver/transmitter pair.
// Optional even-parity support is enabled by defining SERIAL_RX_PARITY_EN.
package serial_pkg;

  localparam int   DEFAULT_DATA_W = 8;
  localparam logic IDLE_LEVEL     = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    RECOVER
  } rx_state_t;

endpackage

// File: rtl/serial_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module serial_sync2
  import serial_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state is always written with non-blocking assignments so every
  // flop samples its inputs from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= IDLE_LEVEL;
      q    <= IDLE_LEVEL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_receiver.sv
// Oversampling serial receiver: start, DATA_W bits LSB first, stop.
// Define SERIAL_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              busy,
  output logic              frame_err
`ifdef SERIAL_RX_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  rx_state_t         state;
  logic              rx_s;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
`ifdef SERIAL_RX_PARITY_EN
  logic              parity_bad;
`endif

  serial_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_in),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_bad <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rx_s != IDLE_LEVEL) begin
            state   <= START;
            busy    <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
          end
        end

        // Re-check the line mid start bit so short glitches are dropped silently.
        START: begin
          if (cnt == HALF_END) begin
            cnt <= '0;
            if (rx_s == IDLE_LEVEL) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Right-shifting DATA_W times lands the first (LSB) bit at position 0.
        DATA: begin
          if (cnt == BIT_END) begin
            cnt       <= '0;
            shift_reg <= {rx_s, shift_reg[DATA_W-1:1]};
            if (bit_cnt == BIT_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_END) begin
            cnt        <= '0;
            parity_bad <= (^shift_reg) ^ rx_s;
            state      <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif

        STOP: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            if (rx_s == IDLE_LEVEL) begin
              state <= IDLE;
              busy  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
              if (parity_bad) begin
                parity_err <= 1'b1;
              end else begin
                data_out <= shift_reg;
                valid    <= 1'b1;
              end
`else
              data_out <= shift_reg;
              valid    <= 1'b1;
`endif
            end else begin
              frame_err <= 1'b1;
              state     <= RECOVER;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // A line stuck low after a bad stop bit must not look like a new start.
        RECOVER: begin
          if (rx_s == IDLE_LEVEL) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
